hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that owns the HI/LO register pair.
- Successor to the single-cycle HI/LO register file. Adds MULT/MULTU/DIV/DIVU with a start/busy/done handshake, a pipeline stall request, and flush cancellation.
- Sits beside the ALU in the execute stage and takes forwarded operands.
- HI/LO read ports feed the MFHI/MFLO writeback path.

Parameters:
- WIDTH, 32, operand width and HI/LO width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to issue op in this cycle.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- srca  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- srcb  in  WIDTH  rt operand: multiplier or divisor.
- cancel  in  1  flush; aborts any in-flight or same-cycle operation.
- busy  out  1  unit is not IDLE.
- done  out  1  one-cycle pulse after HI/LO receive a mul/div result.
- stall  out  1  pipeline hold request.
- hi  out  WIDTH  current HI.
- lo  out  WIDTH  current LO.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=0, lo=0, counter=0, done=0, internal registers=0.
- States:
  - IDLE -> CALC on start & ~cancel & op in {0..3}.
  - CALC -> FIX when counter==WIDTH-1.
  - FIX -> IDLE.
  - cancel in CALC or FIX -> IDLE.
- Operand latch on issue:
  - srca and srcb are latched; counter=0.
  - Signed ops (0, 2) latch absolute values and record sign flags: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- CALC, one iteration per cycle, counter++:
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIX (single cycle):
  - Apply two's-complement sign correction.
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, hi=remainder.
  - done=1 in the following cycle only.
- Latency: result is visible on hi/lo WIDTH+1 cycles after the issuing edge. busy is high for exactly WIDTH+1 cycles.
- Divide by zero: lo={WIDTH{1'b1}}, hi=original srca, for both DIV and DIVU. Full latency still applies.
- DIV of the most negative value by -1: lo=most negative value, hi=0.
- MTHI/MTLO:
  - Accepted only in IDLE with start & ~cancel.
  - Writes hi (or lo) with srca at that edge; the other register is unchanged; no busy, no done.
- start while busy: ignored. The pipeline is held by stall, so this case only arises on bench misuse.
- start with op 6 or 7: no effect.
- stall = busy | (start & ~cancel & op<=3), combinational. The issuing instruction therefore holds in execute for WIDTH+2 cycles total.
- cancel:
  - In CALC or FIX: returns to IDLE next edge; hi/lo unchanged; no done.
  - cancel & start in IDLE: cancel wins; nothing issues.
- hi/lo change only at a FIX edge, an MTHI/MTLO edge, or reset.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply ops leave CALC for FIX as soon as the remaining unprocessed multiplier bits are all zero, checked at the issuing edge and every CALC edge.
  - A multiply whose latched |srcb| is 0 or 1 completes in minimum time: 1 CALC cycle + FIX.
  - Divide latency is unaffected.
- Undefined:
  - All mul/div ops take exactly WIDTH+1 busy cycles.

Test Plan:
- Reset then MTHI 0xDEADBEEF, then MTLO 0x12345678 -> hi=0xDEADBEEF, lo=0x12345678; busy never asserted.
- MULT srca=0xFFFFFFFE (-2), srcb=0x00000003, WIDTH=32 -> busy 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV srca=-7 (0xFFFFFFF9), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same operands with DIVU -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU srca=0x00000064, srcb=0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 busy cycles. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 5x7 with cancel asserted on busy cycle 10 -> busy drops next cycle; no done; hi/lo keep prior values. Then MULTU 5x7 uninterrupted -> lo=35, hi=0.
- rst pulsed low mid-CALC -> busy=0, hi=lo=0 immediately. With MULDIV_EARLY_OUT_EN, MULTU 0x1234x1 -> busy 2 cycles; lo=0x1234.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Ports: clk, rst (async, active-low), start, op[2:0], srca, srcb, cancel in;
//        busy, done, stall, hi, lo out. Optional macro: MULDIV_EARLY_OUT_EN.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mc_q, mc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_q, div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             done_q, done_d;

    logic             req, issue, sgn, last;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   trial;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quot, rem, quot_fix, rem_fix;

    assign req   = start & ~cancel;
    assign issue = req & ~op[2];
    // op 0 and 2 are the signed variants
    assign sgn   = ~op[0];
    assign a_abs = (sgn & srca[WIDTH-1]) ? -srca : srca;
    assign b_abs = (sgn & srcb[WIDTH-1]) ? -srcb : srcb;

    // acc holds {remainder, quotient}; divisor sits in mc low half
    assign trial = acc_q[W2-1:WIDTH-1] - {1'b0, mc_q[WIDTH-1:0]};

    assign prod     = negq_q ? -acc_q : acc_q;
    assign quot     = acc_q[WIDTH-1:0];
    assign rem      = acc_q[W2-1:WIDTH];
    // divide by zero leaves rem=|a|, so sign fix restores original srca
    assign quot_fix = (mc_q[WIDTH-1:0] == '0) ? '1 :
                      (negq_q ? -quot : quot);
    assign rem_fix  = negr_q ? -rem : rem;

`ifdef MULDIV_EARLY_OUT_EN
    assign last = (cnt_q == CNT_W'(WIDTH - 1)) |
                  (~div_q & (mq_q[WIDTH-1:1] == '0));
`else
    assign last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mq_d    = mq_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    div_d   = op[1];
                    negq_d  = sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    negr_d  = sgn & srca[WIDTH-1];
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, a_abs};
                        mc_d  = {{WIDTH{1'b0}}, b_abs};
                        mq_d  = '0;
                    end else begin
                        acc_d = '0;
                        mc_d  = {{WIDTH{1'b0}}, a_abs};
                        mq_d  = b_abs;
                    end
                end else if (req && op == 3'd4) begin
                    hi_d = srca;
                end else if (req && op == 3'd5) begin
                    lo_d = srca;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (div_q) begin
                        if (!trial[WIDTH])
                            acc_d = {trial[WIDTH-1:0],
                                     acc_q[WIDTH-2:0], 1'b1};
                        else
                            acc_d = {acc_q[W2-2:0], 1'b0};
                    end else begin
                        acc_d = acc_q + (mq_q[0] ? mc_q : '0);
                        mc_d  = mc_q << 1;
                        mq_d  = mq_q >> 1;
                    end
                    if (last)
                        state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod[W2-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mq_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mq_q    <= mq_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy | issue;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors, scoreboard queue, done-driven monitor.
// Expected HI/LO and busy-cycle counts are hand-computed constants.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int C_MULT = 3;
    localparam int C_5X7  = 4;
    localparam int C_ONE  = 2;
    localparam int C_CXL  = 2;
`else
    localparam int C_MULT = 33;
    localparam int C_5X7  = 33;
    localparam int C_ONE  = 33;
    localparam int C_CXL  = 10;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         busy, done, stall;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   nchk = 0;
    int   nerr = 0;
    int   bcnt = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .cancel(cancel),
        .busy(busy), .done(done), .stall(stall),
        .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) begin
            bcnt++;
        end else if (done) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL spurious_done: got done=1 expected 0");
            end else begin
                me = sb.pop_front();
                chk("res_hi", hi, me.hi);
                chk("res_lo", lo, me.lo);
                chk("busy_cycles", W'(bcnt), W'(me.cyc));
            end
            bcnt = 0;
        end else begin
            bcnt = 0;
        end
    end

    task automatic run(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input int cyc);
        exp_t e;
        int   k;
        e.hi = eh;
        e.lo = el;
        e.cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 op = o; srca = a; srcb = b; start = 1'b1;
        #1 chk("stall_issue", W'(stall), W'(1));
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL done_timeout: got no done expected done");
        end
        @(posedge clk);
    endtask

    task automatic mt(input logic [2:0] o, input logic [W-1:0] a);
        @(posedge clk);
        #1 op = o; srca = a; start = 1'b1;
        #1 chk("mt_stall", W'(stall), '0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("mt_busy", W'(busy), '0);
    endtask

    task automatic cxl(input int n, input logic [W-1:0] eh,
                       input logic [W-1:0] el);
        int k;
        int t;
        @(posedge clk);
        #1 op = 3'd1; srca = 32'd5; srcb = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        t = 0;
        while (k < n && t < 100) begin
            @(negedge clk);
            t++;
            if (busy) k++;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("cxl_busy", W'(busy), '0);
        chk("cxl_hi", hi, eh);
        chk("cxl_lo", lo, el);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b0;
        #10;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        @(negedge clk);
        rst = 1'b1;

        mt(3'd4, 32'hDEADBEEF);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_lo", lo, '0);
        mt(3'd5, 32'h12345678);
        chk("mtlo_hi", hi, 32'hDEADBEEF);
        chk("mtlo_lo", lo, 32'h12345678);

        run(3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, C_MULT);
        run(3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run(3'd3, 32'hFFFFFFF9, 32'h2, 32'h1, 32'h7FFFFFFC, 33);
        run(3'd3, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF, 33);
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        run(3'd2, 32'hFFFFFF9C, 32'h0, 32'hFFFFFF9C, 32'hFFFFFFFF, 33);

        cxl(C_CXL, 32'hFFFFFF9C, 32'hFFFFFFFF);
        cxl(C_5X7, 32'hFFFFFF9C, 32'hFFFFFFFF);

        run(3'd1, 32'd5, 32'd7, 32'h0, 32'd35, C_5X7);
        run(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, C_ONE);

        @(posedge clk);
        #1 op = 3'd0; srca = 32'd3; srcb = 32'd3;
        start = 1'b1; cancel = 1'b1;
        #1 chk("cs_stall", W'(stall), '0);
        @(posedge clk);
        #1 start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("cs_busy", W'(busy), '0);
        chk("cs_lo", lo, 32'h1);

        @(posedge clk);
        #1 op = 3'd6; srca = 32'hAAAA5555; start = 1'b1;
        #1 chk("nop_stall", W'(stall), '0);
        @(posedge clk);
        #1 op = 3'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("nop_busy", W'(busy), '0);
        chk("nop_hi", hi, 32'h0);
        chk("nop_lo", lo, 32'h1);

        @(posedge clk);
        #1 op = 3'd1; srca = 32'hFFFF; srcb = 32'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_pre", W'(busy), W'(1));
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", W'(busy), '0);
        chk("mid_hi", hi, '0);
        chk("mid_lo", lo, '0);
        @(negedge clk);
        rst = 1'b1;

`ifdef MULDIV_EARLY_OUT_EN
        run(3'd1, 32'h1234, 32'h1, 32'h0, 32'h1234, 2);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", W'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
